// File: rtl/zoom_cmd_scheduler.sv
// Zoom command scheduler: arbitrates two requesters, validates/saturates, applies at the next vsync rise.
// Latency: zoom-in byte 1 cycle after vs_rise, zoom-out byte 2 cycles after, done 3 cycles after.
// Backpressure: a_ready/b_ready are held low while a command is pending or issuing; requests wait, never drop.
module zoom_cmd_scheduler #(
   parameter int unsigned MAX_ZOOM_IN  = 3,
   parameter int unsigned MAX_ZOOM_OUT = 2,
   parameter logic [7:0]  IDLE_CMD     = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync,
   input  logic       a_valid,
   input  logic [7:0] a_cmd,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic [7:0] b_cmd,
   output logic       b_ready,
   output logic [7:0] command_out,
   output logic [3:0] zoom_in_cur,
   output logic [3:0] zoom_out_cur,
   output logic       busy,
   output logic       done,
   output logic       cmd_err
);

   localparam logic [3:0] MAX_IN  = MAX_ZOOM_IN[3:0];
   localparam logic [3:0] MAX_OUT = MAX_ZOOM_OUT[3:0];

   typedef enum logic [2:0] {
      S_IDLE,
      S_PEND,
      S_ISSUE_IN,
      S_ISSUE_OUT,
      S_DONE
   } state_t;

   state_t     state, state_nx;
   logic       vs_d;
   logic       vs_rise;
   logic       last_grant_b;
   logic       a_hs, b_hs, hs;
   logic [7:0] cmd_sel;
   logic [3:0] opc, val;
   logic       legal;
   logic [3:0] nx_in, nx_out;
   logic [3:0] pend_in, pend_out;
   logic [7:0] cmd_nx;

   assign vs_rise = vsync & ~vs_d;

   // Round-robin on ties: the requester not granted last time wins.
   assign a_ready = (state == S_IDLE) & a_valid & (~b_valid | last_grant_b);
   assign b_ready = (state == S_IDLE) & b_valid & (~a_valid | ~last_grant_b);
   assign a_hs    = a_valid & a_ready;
   assign b_hs    = b_valid & b_ready;
   assign hs      = a_hs | b_hs;
   assign cmd_sel = a_hs ? a_cmd : b_cmd;
   assign opc     = cmd_sel[7:4];
   assign val     = cmd_sel[3:0];

   always_comb begin
      legal  = 1'b1;
      nx_in  = zoom_in_cur;
      nx_out = zoom_out_cur;
      case (opc)
         4'h0: if (val > MAX_IN) legal = 1'b0; else nx_in = val;
         4'h1: if (val > MAX_OUT) legal = 1'b0; else nx_out = val;
         4'h2: nx_in  = (zoom_in_cur >= MAX_IN) ? MAX_IN : zoom_in_cur + 4'd1;
         4'h3: nx_in  = (zoom_in_cur == 4'd0) ? 4'd0 : zoom_in_cur - 4'd1;
         4'h4: nx_out = (zoom_out_cur >= MAX_OUT) ? MAX_OUT : zoom_out_cur + 4'd1;
         4'h5: nx_out = (zoom_out_cur == 4'd0) ? 4'd0 : zoom_out_cur - 4'd1;
         4'hF: begin
            nx_in  = 4'd0;
            nx_out = 4'd0;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      cmd_nx   = IDLE_CMD;
      case (state)
         S_IDLE:      if (hs && legal) state_nx = S_PEND;
         // Only rises seen while already pending count, so a rise on the accept cycle is skipped.
         S_PEND:      if (vs_rise) state_nx = S_ISSUE_IN;
         S_ISSUE_IN:  state_nx = S_ISSUE_OUT;
         S_ISSUE_OUT: state_nx = S_DONE;
         S_DONE:      state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
      case (state_nx)
         S_ISSUE_IN:  cmd_nx = {4'h0, pend_in};
         S_ISSUE_OUT: cmd_nx = {4'h1, pend_out};
         default:     cmd_nx = IDLE_CMD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         vs_d         <= 1'b0;
         last_grant_b <= 1'b1;
         pend_in      <= 4'd0;
         pend_out     <= 4'd0;
         zoom_in_cur  <= 4'd0;
         zoom_out_cur <= 4'd0;
         command_out  <= IDLE_CMD;
         busy         <= 1'b0;
         done         <= 1'b0;
         cmd_err      <= 1'b0;
      end else begin
         state       <= state_nx;
         vs_d        <= vsync;
         command_out <= cmd_nx;
         busy        <= (state_nx != S_IDLE);
         done        <= (state_nx == S_DONE);
         cmd_err     <= hs & ~legal;
         if (a_hs)
            last_grant_b <= 1'b0;
         else if (b_hs)
            last_grant_b <= 1'b1;
         if (hs && legal) begin
            pend_in  <= nx_in;
            pend_out <= nx_out;
         end
         if (state == S_ISSUE_OUT) begin
            zoom_in_cur  <= pend_in;
            zoom_out_cur <= pend_out;
         end
      end
   end

endmodule

// File: tb/tb_zoom_cmd_scheduler.sv
// Self-checking bench for zoom_cmd_scheduler: expected byte pairs queued on accept, compared on issue.
module tb_zoom_cmd_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vsync = 1'b0;
   logic       a_valid = 1'b0;
   logic [7:0] a_cmd = 8'h00;
   logic       a_ready;
   logic       b_valid = 1'b0;
   logic [7:0] b_cmd = 8'h00;
   logic       b_ready;
   logic [7:0] command_out;
   logic [3:0] zoom_in_cur;
   logic [3:0] zoom_out_cur;
   logic       busy;
   logic       done;
   logic       cmd_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] sb[$];
   int          m_in  = 0;
   int          m_out = 0;

   zoom_cmd_scheduler #(
      .MAX_ZOOM_IN (3),
      .MAX_ZOOM_OUT(2),
      .IDLE_CMD    (8'hFF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vsync       (vsync),
      .a_valid     (a_valid),
      .a_cmd       (a_cmd),
      .a_ready     (a_ready),
      .b_valid     (b_valid),
      .b_cmd       (b_cmd),
      .b_ready     (b_ready),
      .command_out (command_out),
      .zoom_in_cur (zoom_in_cur),
      .zoom_out_cur(zoom_out_cur),
      .busy        (busy),
      .done        (done),
      .cmd_err     (cmd_err)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference behaviour, written from the opcode table with plain integers.
   function automatic void model_cmd(input logic [7:0] cmd, input int ci, input int co,
                                     output bit legal, output int ni, output int no);
      int v;
      v = int'(cmd[3:0]);
      legal = 1'b1;
      ni = ci;
      no = co;
      case (cmd[7:4])
         4'h0: if (v <= 3) ni = v; else legal = 1'b0;
         4'h1: if (v <= 2) no = v; else legal = 1'b0;
         4'h2: ni = (ci + 1 > 3) ? 3 : ci + 1;
         4'h3: ni = (ci - 1 < 0) ? 0 : ci - 1;
         4'h4: no = (co + 1 > 2) ? 2 : co + 1;
         4'h5: no = (co - 1 < 0) ? 0 : co - 1;
         4'hF: begin ni = 0; no = 0; end
         default: legal = 1'b0;
      endcase
   endfunction

   task automatic push_expect(input logic [7:0] cmd, output bit legal);
      int ni, no;
      model_cmd(cmd, m_in, m_out, legal, ni, no);
      if (legal) begin
         sb.push_back({4'h0, 4'(ni), 4'h1, 4'(no)});
         m_in  = ni;
         m_out = no;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      vsync = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      m_in = 0;
      m_out = 0;
   endtask

   // Drives one request until accepted; reports acceptance and the cmd_err pulse that follows.
   task automatic handshake(input bit use_b, input logic [7:0] cmd, output bit got, output bit err);
      got = 1'b0;
      err = 1'b0;
      if (use_b) begin b_valid = 1'b1; b_cmd = cmd; end
      else begin a_valid = 1'b1; a_cmd = cmd; end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (use_b ? b_ready : a_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1 a_valid = 1'b0;
      b_valid = 1'b0;
      @(negedge clk);
      err = cmd_err;
      @(posedge clk);
      #1;
   endtask

   // One-cycle vsync pulse, then captures the issued bytes; lat is cycles from the rise cycle.
   task automatic issue_frame(output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] aft,
                              output bit d, output int lat);
      b0 = 8'hFF; b1 = 8'hFF; aft = 8'hFF; d = 1'b0; lat = -1;
      vsync = 1'b1;
      @(posedge clk);
      #1 vsync = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (command_out !== 8'hFF) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) return;
      b0 = command_out;
      @(negedge clk);
      b1 = command_out;
      @(negedge clk);
      aft = command_out;
      d = done;
      @(posedge clk);
      #1;
   endtask

   task automatic frame_and_compare(input string tag);
      logic [7:0]  b0, b1, aft;
      logic [15:0] exp;
      bit          d;
      int          lat;
      issue_frame(b0, b1, aft, d, lat);
      exp = 16'hFFFF;
      if (sb.size() > 0) exp = sb.pop_front();
      n_tests++;
      if (lat !== 1) begin n_fail++; $display("FAIL %s latency: got %0d want 1", tag, lat); end
      n_tests++;
      if (b0 !== exp[15:8]) begin n_fail++; $display("FAIL %s zoom_in byte: got %h want %h", tag, b0, exp[15:8]); end
      n_tests++;
      if (b1 !== exp[7:0]) begin n_fail++; $display("FAIL %s zoom_out byte: got %h want %h", tag, b1, exp[7:0]); end
      n_tests++;
      if (aft !== 8'hFF || d !== 1'b1) begin
         n_fail++; $display("FAIL %s done/idle: got cmd %h done %0b want ff 1", tag, aft, d);
      end
      n_tests++;
      if (zoom_in_cur !== 4'(m_in) || zoom_out_cur !== 4'(m_out)) begin
         n_fail++; $display("FAIL %s cur: got %0d/%0d want %0d/%0d", tag, zoom_in_cur, zoom_out_cur, m_in, m_out);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_tests++;
      if (command_out !== 8'hFF) begin n_fail++; $display("FAIL reset command_out: got %h want ff", command_out); end
      n_tests++;
      if (zoom_in_cur !== 4'd0 || zoom_out_cur !== 4'd0) begin
         n_fail++; $display("FAIL reset cur: got %0d/%0d want 0/0", zoom_in_cur, zoom_out_cur);
      end
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0) begin
         n_fail++; $display("FAIL reset flags: got busy %0b done %0b err %0b want 0 0 0", busy, done, cmd_err);
      end
      n_tests++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset ready: got %0b/%0b want 0/0", a_ready, b_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      bit got, err, legal;
      push_expect(8'h01, legal);
      handshake(1'b0, 8'h01, got, err);
      n_tests++;
      if (got !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL basic accept: got %0b err %0b want 1 0", got, err); end
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL basic busy: got %0b want 1", busy); end
      frame_and_compare("basic");
   endtask

   task automatic test_saturate();
      logic [7:0] cmds[8] = '{8'h03, 8'h22, 8'h52, 8'h41, 8'h41, 8'h41, 8'h31, 8'hF0};
      bit         ports[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      bit         got, err, legal;
      for (int i = 0; i < 8; i++) begin
         push_expect(cmds[i], legal);
         handshake(ports[i], cmds[i], got, err);
         n_tests++;
         if (got !== 1'b1 || err !== !legal) begin
            n_fail++; $display("FAIL sat accept %h: got %0b err %0b want 1 %0b", cmds[i], got, err, !legal);
         end
         frame_and_compare($sformatf("sat_%h", cmds[i]));
      end
   endtask

   task automatic test_illegal();
      logic [7:0] cmds[4] = '{8'h07, 8'h6A, 8'h13, 8'h8F};
      bit         got, err, legal;
      int         ci, co;
      ci = m_in;
      co = m_out;
      for (int i = 0; i < 4; i++) begin
         push_expect(cmds[i], legal);
         handshake(1'b0, cmds[i], got, err);
         n_tests++;
         if (got !== 1'b1 || err !== 1'b1) begin
            n_fail++; $display("FAIL illegal %h err: got acc %0b err %0b want 1 1", cmds[i], got, err);
         end
         @(negedge clk);
         n_tests++;
         if (cmd_err !== 1'b0 || busy !== 1'b0 || command_out !== 8'hFF) begin
            n_fail++; $display("FAIL illegal %h after: got err %0b busy %0b cmd %h want 0 0 ff", cmds[i], cmd_err, busy, command_out);
         end
         n_tests++;
         if (zoom_in_cur !== 4'(ci) || zoom_out_cur !== 4'(co) || sb.size() != 0) begin
            n_fail++; $display("FAIL illegal %h cur: got %0d/%0d want %0d/%0d", cmds[i], zoom_in_cur, zoom_out_cur, ci, co);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_arbitration();
      bit   legal, a_won, timed_out;
      bit   exp_a[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      do_reset();
      a_cmd = 8'h21;
      b_cmd = 8'h41;
      a_valid = 1'b1;
      b_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         timed_out = 1'b1;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_ready || b_ready) begin timed_out = 1'b0; break; end
         end
         a_won = a_ready;
         n_tests++;
         if (timed_out || (a_ready && b_ready) || a_won !== exp_a[k]) begin
            n_fail++; $display("FAIL arb grant %0d: got a %0b b %0b want a %0b", k, a_ready, b_ready, exp_a[k]);
         end
         push_expect(a_won ? a_cmd : b_cmd, legal);
         @(posedge clk);
         #1;
         @(negedge clk);
         n_tests++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL arb hold %0d: got a %0b b %0b busy %0b want 0 0 1", k, a_ready, b_ready, busy);
         end
         @(posedge clk);
         #1;
         frame_and_compare($sformatf("arb_%0d", k));
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_vsync_hold();
      bit got, err, legal;
      int bad;
      push_expect(8'h02, legal);
      vsync = 1'b1;
      handshake(1'b0, 8'h02, got, err);
      n_tests++;
      if (got !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL hold accept: got %0b err %0b want 1 0", got, err); end
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (i == 500) vsync = 1'b0;
         if (busy !== 1'b1 || command_out !== 8'hFF) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL hold wait: got %0d bad cycles want 0", bad); end
      @(posedge clk);
      #1;
      frame_and_compare("hold");
   endtask

   task automatic test_reset_mid();
      bit got, err, legal;
      int bad;
      push_expect(8'h03, legal);
      handshake(1'b0, 8'h03, got, err);
      vsync = 1'b1;
      @(posedge clk);
      #1 vsync = 1'b0;
      @(negedge clk);
      n_tests++;
      if (command_out !== 8'h03) begin n_fail++; $display("FAIL midrst issue_in: got %h want 03", command_out); end
      rst = 1'b0;
      #1;
      n_tests++;
      if (command_out !== 8'hFF || zoom_in_cur !== 4'd0 || zoom_out_cur !== 4'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL midrst abort: got cmd %h cur %0d/%0d busy %0b want ff 0/0 0", command_out, zoom_in_cur, zoom_out_cur, busy);
      end
      sb.delete();
      m_in = 0;
      m_out = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || command_out !== 8'hFF || busy !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL midrst after: got %0d bad cycles want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_illegal();
      test_arbitration();
      test_vsync_hold();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
